// File: rtl/writeback_unit_pkg.sv
// ---------------------------------------------------------------------------
// writeback_unit_pkg
// Shared constants for the writeback stage: RV32 opcode values, the
// writeback-source select encoding, load funct3 encodings and the FSM state
// type. Also provides a helper that classifies register-writing opcodes.
// ---------------------------------------------------------------------------
package writeback_unit_pkg;

  // Major opcodes (inst[6:0]) of the instructions that write rd.
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  // Writeback-source select driven by earlier stages.
  typedef enum logic [1:0] {
    WB_MEM  = 2'b00,
    WB_ALU  = 2'b01,
    WB_PC4  = 2'b10,
    WB_NONE = 2'b11
  } wb_sel_e;

  // Load width/sign encodings carried in funct3.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Writeback FSM: either free, or parked waiting for load response data.
  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

  // True for every opcode whose result is written to the register file.
  function automatic logic is_writing_opcode(input logic [6:0] opc);
    logic result;
    case (opc)
      OPC_LOAD, OPC_ARI_RTYPE, OPC_ARI_ITYPE, OPC_AUIPC,
      OPC_LUI, OPC_JAL, OPC_JALR: result = 1'b1;
      default:                    result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// ---------------------------------------------------------------------------
// writeback_unit_if
// Bundles the stage-3 retirement inputs, the data-memory response and the
// register-file write port of the writeback stage.
//   master : pipeline/memory side (drives stage-3 and dmem, sees stall + rf_*)
//   slave  : writeback_unit side
// Signals:
//   stage3_valid, stage3_inst[31:0], wb_sel[1:0], alu_result[XLEN-1:0],
//   stage3_pc[XLEN-1:0], dmem_rdata[31:0], dmem_rvalid  -> into writeback
//   stall, rf_we, rf_waddr[4:0], rf_wdata[XLEN-1:0]     <- from writeback
// ---------------------------------------------------------------------------
interface writeback_unit_if #(
  parameter int XLEN = 32
);
  logic            stage3_valid;
  logic [31:0]     stage3_inst;
  logic [1:0]      wb_sel;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] stage3_pc;
  logic [31:0]     dmem_rdata;
  logic            dmem_rvalid;
  logic            stall;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  modport master (
    output stage3_valid, stage3_inst, wb_sel, alu_result, stage3_pc,
    output dmem_rdata, dmem_rvalid,
    input  stall, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  stage3_valid, stage3_inst, wb_sel, alu_result, stage3_pc,
    input  dmem_rdata, dmem_rvalid,
    output stall, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/writeback_unit_load_formatter.sv
// ---------------------------------------------------------------------------
// writeback_unit_load_formatter
// Purely combinational load-data alignment and extension. Picks the byte or
// halfword addressed by the low address bits out of a 32-bit memory word and
// sign- or zero-extends it to XLEN according to funct3.
// Ports:
//   funct3 [2:0]      load type (LB/LH/LW/LBU/LHU; others = full word)
//   offset [1:0]      byte offset inside the word (address bits [1:0])
//   word   [31:0]     raw data-memory read word
//   data   [XLEN-1:0] formatted writeback value
// ---------------------------------------------------------------------------
module writeback_unit_load_formatter
  import writeback_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [31:0]     word,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection. Halfwords always come from the floor halfword (offset[1]),
  // so a misaligned halfword access quietly reads the aligned one instead of
  // trapping.
  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];
  end

  // Extension. A size cast of a signed operand sign-extends, of an unsigned
  // one zero-extends. Unknown funct3 values fall back to the full word.
  always_comb begin
    data = XLEN'($signed(word));
    case (funct3)
      F3_LB:   data = XLEN'($signed(byte_sel));
      F3_LBU:  data = XLEN'(byte_sel);
      F3_LH:   data = XLEN'($signed(half_sel));
      F3_LHU:  data = XLEN'(half_sel);
      F3_LW:   data = XLEN'($signed(word));
      default: data = XLEN'($signed(word));
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// ---------------------------------------------------------------------------
// writeback_unit
// Stage-3 writeback: selects the retiring instruction's result (memory, ALU
// or PC+4), formats load data, and drives the register-file write port
// through one output register. Loads whose data is not yet available park
// the FSM in WAIT_LOAD and hold the pipeline with a combinational stall.
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   bus          writeback_unit_if.slave (stage-3 inputs, dmem response,
//                stall, rf_we/rf_waddr/rf_wdata)
//   load_timeout one-cycle pulse when a load is abandoned (option only)
// Configuration:
//   WB_LOAD_TIMEOUT_EN  when defined, a load waiting LOAD_TIMEOUT cycles in
//                       WAIT_LOAD is abandoned without a register write and
//                       load_timeout pulses. When undefined, WAIT_LOAD waits
//                       indefinitely and the port/parameter do not exist.
// ---------------------------------------------------------------------------
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int XLEN = 32
`ifdef WB_LOAD_TIMEOUT_EN
  ,
  parameter int LOAD_TIMEOUT = 64
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  writeback_unit_if.slave  bus
`ifdef WB_LOAD_TIMEOUT_EN
  ,
  output logic             load_timeout
`endif
);

  wb_state_e state_q, state_d;

  // Live instruction fields.
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [1:0] offset;
  wb_sel_e    sel;
  logic       inst_writes;

  // Copy of the parked load, captured when entering WAIT_LOAD.
  logic [4:0] rd_q;
  logic [2:0] funct3_q;
  logic [1:0] offset_q;
  logic       latch_load;

  // Next values for the registered write port.
  logic            wr_en_d;
  logic [4:0]      wr_addr_d;
  logic [XLEN-1:0] wr_data_d;

  logic            rf_we_q;
  logic [4:0]      rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic            stall_c;

  logic [2:0]      fmt_funct3;
  logic [1:0]      fmt_offset;
  logic [XLEN-1:0] fmt_data;

  logic unused_inst_bits;

  assign opcode      = bus.stage3_inst[6:0];
  assign rd          = bus.stage3_inst[11:7];
  assign funct3      = bus.stage3_inst[14:12];
  assign offset      = bus.alu_result[1:0];
  assign sel         = wb_sel_e'(bus.wb_sel);
  assign inst_writes = bus.stage3_valid && is_writing_opcode(opcode) &&
                       (rd != 5'd0) && (sel != WB_NONE);

  assign unused_inst_bits = ^bus.stage3_inst[31:15];

  // The formatter sees the live load in IDLE and the parked copy in
  // WAIT_LOAD, so stage-3 inputs can change freely while we wait.
  assign fmt_funct3 = (state_q == WAIT_LOAD) ? funct3_q : funct3;
  assign fmt_offset = (state_q == WAIT_LOAD) ? offset_q : offset;

  writeback_unit_load_formatter #(
    .XLEN (XLEN)
  ) u_load_formatter (
    .funct3 (fmt_funct3),
    .offset (fmt_offset),
    .word   (bus.dmem_rdata),
    .data   (fmt_data)
  );

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

  logic [CNT_W-1:0] wait_cnt_q;
  logic             load_timeout_q;
  logic             wait_expired;

  // The final permitted WAIT_LOAD cycle is the one where the counter shows
  // LOAD_TIMEOUT-1; rvalid in that cycle still wins in the FSM below.
  assign wait_expired = (wait_cnt_q == CNT_W'(LOAD_TIMEOUT - 1));
`endif

  // Next-state and write-port decode. Stall is combinational so the
  // pipeline holds in the very cycle a load finds no data.
  always_comb begin
    state_d    = state_q;
    stall_c    = 1'b0;
    latch_load = 1'b0;
    wr_en_d    = 1'b0;
    wr_addr_d  = rd;
    wr_data_d  = bus.alu_result;

    case (state_q)
      IDLE: begin
        if (inst_writes) begin
          case (sel)
            WB_ALU: begin
              wr_en_d   = 1'b1;
              wr_data_d = bus.alu_result;
            end
            WB_PC4: begin
              wr_en_d   = 1'b1;
              wr_data_d = bus.stage3_pc + XLEN'(4);
            end
            WB_MEM: begin
              if (bus.dmem_rvalid) begin
                wr_en_d   = 1'b1;
                wr_data_d = fmt_data;
              end else begin
                stall_c    = 1'b1;
                latch_load = 1'b1;
                state_d    = WAIT_LOAD;
              end
            end
            default: wr_en_d = 1'b0;
          endcase
        end
      end

      WAIT_LOAD: begin
        wr_addr_d = rd_q;
        wr_data_d = fmt_data;
        if (bus.dmem_rvalid) begin
          wr_en_d = 1'b1;
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
`ifdef WB_LOAD_TIMEOUT_EN
          if (wait_expired) begin
            state_d = IDLE;
          end
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, parked-load copy and the write-port register. Address and data
  // only move on a write so they hold their last values between writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      funct3_q   <= '0;
      offset_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rf_we_q <= wr_en_d;
      if (latch_load) begin
        rd_q     <= rd;
        funct3_q <= funct3;
        offset_q <= offset;
      end
      if (wr_en_d) begin
        rf_waddr_q <= wr_addr_d;
        rf_wdata_q <= wr_data_d;
      end
    end
  end

`ifdef WB_LOAD_TIMEOUT_EN
  // Wait counter restarts on every load that parks and advances on each
  // WAIT_LOAD cycle with no response; the pulse marks an abandoned load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q     <= '0;
      load_timeout_q <= 1'b0;
    end else begin
      load_timeout_q <= (state_q == WAIT_LOAD) && !bus.dmem_rvalid && wait_expired;
      if (latch_load) begin
        wait_cnt_q <= '0;
      end else if ((state_q == WAIT_LOAD) && !bus.dmem_rvalid) begin
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end
    end
  end

  assign load_timeout = load_timeout_q;
`endif

  assign bus.stall    = stall_c;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;

endmodule
